// File: rtl/uart_rx_os.sv
// UART receiver driven by a 16x oversample tick: samples rx at bit centres,
// assembles an LSB-first word and reports it with a done strobe and framing flag.
module uart_rx_os #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bd_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned SW = 5;
    localparam int unsigned NW = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;

    // Synchronizer, frame FSM and registered outputs share one clocked process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            rx_done_tick <= 1'b0;

            case (state)
                IDLE: begin
                    // Start-edge detection needs no tick, so a frame can follow the stop sample directly.
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (bd_tick) begin
                        if (s == SW'(7)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end

                DATA: begin
                    if (bd_tick) begin
                        if (s == SW'(15)) begin
                            s     <= '0;
                            shift <= {rx_s, shift[DBIT-1:1]};
                            if (n == NW'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end

                STOP: begin
                    if (bd_tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            dout         <= shift;
                            rx_done_tick <= 1'b1;
                            frame_err    <= ~rx_s;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: scoreboard of expected words/flags,
// tick generator dividing by 10 (one bit = 160 clk).
module tb_uart_rx_os;

    localparam int unsigned DBIT    = 8;
    localparam int unsigned SB_TICK = 16;
    localparam int          BIT_CLK = 160;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            bd_tick  = 1'b0;
    logic            rx       = 1'b1;
    logic            tick_en  = 1'b1;
    int unsigned     tick_div = 0;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            busy;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    uart_rx_os #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .rst          (rst),
        .bd_tick      (bd_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_done_tick) done_cnt <= done_cnt + 1;
    end

    // Baud generator model: one tick every 10 clk, phase frozen while tick_en is low.
    always @(posedge clk) begin
        if (tick_en) begin
            if (tick_div == 9) begin
                tick_div <= 0;
                bd_tick  <= 1'b1;
            end else begin
                tick_div <= tick_div + 1;
                bd_tick  <= 1'b0;
            end
        end else begin
            bd_tick <= 1'b0;
        end
    end

    function automatic exp_t mk(input logic [7:0] d, input logic f);
        exp_t e;
        e.data = d;
        e.ferr = f;
        return e;
    endfunction

    // Drives one frame starting at a negedge; optional tick pause inside data bit pause_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len,
                              input int pause_bit, input int pause_len);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == pause_bit) begin
                repeat (40) @(negedge clk);
                tick_en = 1'b0;
                repeat (pause_len) @(negedge clk);
                tick_en = 1'b1;
                repeat (BIT_CLK - 40) @(negedge clk);
            end else begin
                repeat (BIT_CLK) @(negedge clk);
            end
        end
        rx = stop_bit;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
        if (stop_len < BIT_CLK) repeat (BIT_CLK - stop_len) @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output bit got, output int at);
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %0h expected 0", dout); end
        checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", rx_done_tick); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single_frame();
        exp_t e;
        bit   got;
        int   at;
        int   t0;
        exp_q.push_back(mk(8'hA5, 1'b0));
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, BIT_CLK, -1, 0);
            wait_done(2000, got, at);
        join
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_done: got %0b expected 1", got); end
        checks++; if (dout !== e.data) begin errors++; $display("FAIL single_dout: got %0h expected %0h", dout, e.data); end
        checks++; if (frame_err !== e.ferr) begin errors++; $display("FAIL single_ferr: got %0b expected %0b", frame_err, e.ferr); end
        checks++; if ((at - t0) < 1512 || (at - t0) > 1544) begin errors++; $display("FAIL single_latency: got %0d expected 1528+-16", at - t0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b expected 0", busy); end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   g1, g2;
        int   a1, a2;
        exp_q.push_back(mk(8'h00, 1'b0));
        exp_q.push_back(mk(8'hFF, 1'b0));
        fork
            begin
                send_frame(8'h00, 1'b1, BIT_CLK, -1, 0);
                send_frame(8'hFF, 1'b1, BIT_CLK, -1, 0);
            end
            begin
                wait_done(2000, g1, a1);
                e = exp_q.pop_front();
                checks++; if (g1 !== 1'b1) begin errors++; $display("FAIL b2b_done0: got %0b expected 1", g1); end
                checks++; if (dout !== e.data) begin errors++; $display("FAIL b2b_dout0: got %0h expected %0h", dout, e.data); end
                checks++; if (frame_err !== e.ferr) begin errors++; $display("FAIL b2b_ferr0: got %0b expected %0b", frame_err, e.ferr); end
                wait_done(2000, g2, a2);
                e = exp_q.pop_front();
                checks++; if (g2 !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %0b expected 1", g2); end
                checks++; if (dout !== e.data) begin errors++; $display("FAIL b2b_dout1: got %0h expected %0h", dout, e.data); end
                checks++; if (frame_err !== e.ferr) begin errors++; $display("FAIL b2b_ferr1: got %0b expected %0b", frame_err, e.ferr); end
                checks++; if ((a2 - a1) < 1584 || (a2 - a1) > 1616) begin errors++; $display("FAIL b2b_spacing: got %0d expected 1600+-16", a2 - a1); end
            end
        join
        repeat (200) @(negedge clk);
    endtask

    task automatic test_glitch();
        int d0;
        bit saw_busy;
        d0       = done_cnt;
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        rx = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %0b expected 1", saw_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %0b expected 0", busy); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL glitch_no_done: got %0d expected %0d", done_cnt, d0); end
        checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL glitch_dout_hold: got %0h expected ff", dout); end
    endtask

    task automatic test_framing_error();
        exp_t e;
        bit   got;
        int   at;
        int   d0;
        exp_q.push_back(mk(8'h3C, 1'b1));
        fork
            send_frame(8'h3C, 1'b0, 100, -1, 0);
            wait_done(2000, got, at);
        join
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL ferr_done: got %0b expected 1", got); end
        checks++; if (dout !== e.data) begin errors++; $display("FAIL ferr_dout: got %0h expected %0h", dout, e.data); end
        checks++; if (frame_err !== e.ferr) begin errors++; $display("FAIL ferr_flag: got %0b expected %0b", frame_err, e.ferr); end
        d0 = done_cnt;
        repeat (320) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL ferr_no_extra_done: got %0d expected %0d", done_cnt, d0); end
        exp_q.push_back(mk(8'h55, 1'b0));
        fork
            send_frame(8'h55, 1'b1, BIT_CLK, -1, 0);
            wait_done(2000, got, at);
        join
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL good_done: got %0b expected 1", got); end
        checks++; if (dout !== e.data) begin errors++; $display("FAIL good_dout: got %0h expected %0h", dout, e.data); end
        checks++; if (frame_err !== e.ferr) begin errors++; $display("FAIL good_ferr: got %0b expected %0b", frame_err, e.ferr); end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        bit   got;
        int   at;
        int   d0;
        d0 = done_cnt;
        fork
            send_frame(8'hF0, 1'b1, BIT_CLK, -1, 0);
            begin
                repeat (5 * BIT_CLK + 1) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
                checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %0h expected 0", dout); end
                checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0b expected 0", rx_done_tick); end
            end
        join
        repeat (100) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected %0d", done_cnt, d0); end
        exp_q.push_back(mk(8'h81, 1'b0));
        fork
            send_frame(8'h81, 1'b1, BIT_CLK, -1, 0);
            wait_done(2000, got, at);
        join
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstmid_next_done: got %0b expected 1", got); end
        checks++; if (dout !== e.data) begin errors++; $display("FAIL rstmid_next_dout: got %0h expected %0h", dout, e.data); end
        repeat (200) @(negedge clk);
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL rstmid_single_done: got %0d expected %0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_tick_pause();
        exp_t e;
        bit   got;
        bit   held;
        bit   paused;
        int   at;
        int   d0;
        exp_q.push_back(mk(8'h6A, 1'b0));
        fork
            send_frame(8'h6A, 1'b1, BIT_CLK, 3, 500);
            begin
                paused = 1'b0;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (tick_en === 1'b0) begin
                        paused = 1'b1;
                        break;
                    end
                end
                d0   = done_cnt;
                held = 1'b1;
                for (int i = 0; i < 600 && tick_en === 1'b0; i++) begin
                    @(negedge clk);
                    if (busy !== 1'b1 || rx_done_tick !== 1'b0) held = 1'b0;
                end
                checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_seen: got %0b expected 1", paused); end
                checks++; if (held !== 1'b1) begin errors++; $display("FAIL pause_frozen: got %0b expected 1", held); end
                checks++; if (done_cnt != d0) begin errors++; $display("FAIL pause_no_done: got %0d expected %0d", done_cnt, d0); end
                wait_done(2600, got, at);
                e = exp_q.pop_front();
                checks++; if (got !== 1'b1) begin errors++; $display("FAIL pause_done: got %0b expected 1", got); end
                checks++; if (dout !== e.data) begin errors++; $display("FAIL pause_dout: got %0h expected %0h", dout, e.data); end
                checks++; if (frame_err !== e.ferr) begin errors++; $display("FAIL pause_ferr: got %0b expected %0b", frame_err, e.ferr); end
            end
        join
        repeat (100) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_tick_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
